// File: rtl/mips_dmem_arbiter.sv
// mips_dmem_arbiter: round-robin arbiter sharing the single-port mips_data_mem between
// port 0 (CPU) and port 1 (DMA/debug). Define DMEM_ARB_LOCK_EN to enable bounded grant locking.
//
// state  | meaning
// IDLE   | nothing in flight, arbitrating every cycle
// ACCESS | memory strobed with the latched request, winner's gnt high
// RESP   | winner's rvalid high, arbitrating for a back-to-back access

module mips_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_gnt0,
    output logic              o_rvalid0,
    output logic [DATA_W-1:0] o_rdata0,

    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt1,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata1,

    input  logic              i_lock0,
    input  logic              i_lock1,

    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_sig_mem_read,
    output logic              o_sig_mem_write,
    input  logic [DATA_W-1:0] i_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_id;
    logic              r_we;
    logic              r_last_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any_req;
    logic              w_arb_en;
    logic              w_rr_win;
    logic              w_win;

    assign w_any_req = i_req0 | i_req1;
    assign w_arb_en  = ((r_state == S_IDLE) || (r_state == S_RESP)) && w_any_req;
    // On a tie the port that did not win last time goes next.
    assign w_rr_win  = (i_req0 && i_req1) ? ~r_last_gnt : i_req1;

`ifdef DMEM_ARB_LOCK_EN
    logic       r_lock_hold;
    logic       r_lock_fresh;
    logic [1:0] r_lock_left;
    logic       w_lock_keep;

    // r_lock_left counts the remaining locked re-grants for the last winner; 0 ends the lock.
    assign w_lock_keep = r_lock_hold && (r_lock_left != 2'd0) &&
                         (r_last_gnt ? i_req1 : i_req0);
    assign w_win       = w_lock_keep ? r_last_gnt : w_rr_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_hold  <= 1'b0;
            r_lock_fresh <= 1'b1;
            r_lock_left  <= 2'd0;
        end else begin
            if (w_arb_en) begin
                if (r_lock_fresh || (w_win != r_last_gnt)) begin
                    r_lock_left  <= 2'd3;
                    r_lock_fresh <= 1'b0;
                end else if (r_lock_left != 2'd0) begin
                    r_lock_left <= r_lock_left - 2'd1;
                end
            end
            if (r_state == S_ACCESS) begin
                r_lock_hold <= r_id ? i_lock1 : i_lock0;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = i_lock0 | i_lock1;
    assign w_win         = w_rr_win;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = w_any_req ? S_ACCESS : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request payload is captured only at an arbitration point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_last_gnt <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_arb_en) begin
            r_id       <= w_win;
            r_last_gnt <= w_win;
            r_we       <= w_win ? i_we1    : i_we0;
            r_addr     <= w_win ? i_addr1  : i_addr0;
            r_wdata    <= w_win ? i_wdata1 : i_wdata0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if ((r_state == S_ACCESS) && !r_we) begin
            if (r_id) begin
                r_rdata1 <= i_read_data;
            end else begin
                r_rdata0 <= i_read_data;
            end
        end
    end

    assign o_gnt0          = (r_state == S_ACCESS) && !r_id;
    assign o_gnt1          = (r_state == S_ACCESS) &&  r_id;
    assign o_rvalid0       = (r_state == S_RESP)   && !r_id;
    assign o_rvalid1       = (r_state == S_RESP)   &&  r_id;
    assign o_rdata0        = r_rdata0;
    assign o_rdata1        = r_rdata1;
    assign o_mem_address   = r_addr;
    assign o_write_data    = r_wdata;
    assign o_sig_mem_write = (r_state == S_ACCESS) &&  r_we;
    assign o_sig_mem_read  = (r_state == S_ACCESS) && !r_we;

endmodule

// File: doc/mips_dmem_arbiter.md
Name: mips_dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port mips_data_mem between port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Round-robin arbitration with a registered req/gnt/rvalid handshake.
- Drives mem_address, write_data, sig_mem_read and sig_mem_write to the memory, and captures read_data into a per-port response register.
- Guarantees that sig_mem_read and sig_mem_write are never high together.

Parameters:
ADDR_W, 32, width of address buses
DATA_W, 32, width of data buses

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 request; held until gnt0 is seen
we0  input  1  port 0 access type: 1 = write, 0 = read
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 grant pulse (one cycle)
rvalid0  output  1  port 0 completion pulse; for reads, rdata0 is valid
rdata0  output  DATA_W  port 0 read data, held until the next port 0 read completes
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for port 1
lock0, lock1  input  1  lock requests; used only with DMEM_ARB_LOCK_EN
mem_address  output  ADDR_W  to mips_data_mem
write_data  output  DATA_W  to mips_data_mem
sig_mem_read  output  1  to mips_data_mem
sig_mem_write  output  1  to mips_data_mem
read_data  input  DATA_W  from mips_data_mem (combinational read)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; last_gnt=1, so port 0 wins the first tie.
  - All outputs go to 0 immediately, including rdata0/1 and the memory controls.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample req0/req1 each clk.
  - Any request present -> latch the winner's id, we, addr and wdata -> ACCESS.
  - No request -> stay in IDLE.
- Arbitration:
  - Only one request -> that port wins.
  - Both requesting -> the port not equal to last_gnt wins. last_gnt updates on entry to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address and write_data are driven from the latched values.
  - sig_mem_write=we and sig_mem_read=!we.
  - gnt of the winner is high for this cycle.
  - On a read, read_data is captured into rdata of the winner at the end of the cycle.
  - Next state is RESP.
- RESP (1 cycle):
  - All memory controls are 0; mem_address and write_data hold their last values.
  - rvalid of the winner is high. rdata updates only on reads; on writes rdata is unchanged.
  - Arbitration runs here exactly as in IDLE.
  - Pending request -> ACCESS (back-to-back, one access every 2 cycles). Otherwise -> IDLE.
- Latency: req sampled at edge N -> gnt high during cycle N+1 -> rvalid high during cycle N+2.
- Handshake rules:
  - The requester keeps req and its payload stable until it sees gnt, then may deassert req in the cycle after gnt.
  - A req still high on the RESP-cycle edge counts as a new request.
  - The payload is latched at IDLE/RESP exit, so changes after that have no effect on the current access.
- Invariants:
  - sig_mem_read & sig_mem_write == 0 in every cycle.
  - gnt0 & gnt1 == 0 and rvalid0 & rvalid1 == 0 in every cycle.
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1...
- Reset mid-ACCESS: sig_mem_write drops asynchronously. The partial write is the requester's responsibility; no rvalid is issued. After reset release, the FSM starts in IDLE.
- Addresses and data pass through unmodified; no alignment check is performed.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - If the winning port has lock high during its ACCESS cycle, it is granted again at the next arbitration point provided its req is high, overriding round-robin.
  - Lock is capped at 4 consecutive grants. After the 4th, the other port wins if it is requesting, and the counter clears.
  - The counter clears on reset and whenever the granted port changes.
- Undefined: lock0/lock1 are ignored and arbitration is pure round-robin. The ports remain in the port list so the interface does not change.

Test Plan:
- Reset then port 0 write (req0=1, we0=1, addr0=0x4, wdata0=0x7F800001) -> gnt0 in cycle 1 with sig_mem_write=1, sig_mem_read=0, mem_address=0x4 -> rvalid0 in cycle 2, rdata0 unchanged (0).
- Port 1 read of addr 0x4 after that write -> sig_mem_read=1 in the ACCESS cycle only -> rvalid1 next cycle with rdata1=0x7F800001.
- req0 and req1 both held high from reset for 8 cycles -> gnt sequence 0,1,0,1 at cycles 1,3,5,7; sig_mem_read & sig_mem_write never both 1.
- rst_n pulled low during a port 0 write ACCESS cycle -> sig_mem_write, gnt0 and rdata0 go to 0 within the same cycle; no rvalid0; first grant after release goes to port 0.
- Payload changed after grant (addr0 changed from 0x8 to 0xC in the RESP cycle, req0 low) -> no new access; the completed access used 0x8.
- With DMEM_ARB_LOCK_EN defined: req0=req1=lock0=1 held continuously -> grants 0,0,0,0,1,0,0,0,0,1; without the macro -> 0,1,0,1...
